// File: rtl/instr_register_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_register_pkg
// Brief    : Shared types for the instruction register and its controller.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_register_pkg;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic        [4:0]  address_t;

  typedef enum logic [2:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rslt;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE, LOAD, READ
  } ctrl_state_t;

  // A DIV or MOD by zero must never reach the register.
  function automatic logic is_div_zero(input opcode_t op, input operand_t b);
    return ((op == DIV) || (op == MOD)) && (b == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_reg_ctrl_arb.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter2
// Brief    : Two-way round-robin arbiter. req[0] is requester A, req[1] is B.
//            On a tie the requester not granted last wins.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  // Last-grant flag: 1 = B was granted last. Resets to B so A wins the first tie.
  logic r_last_b;

  // Grant selection from requests and last-grant history.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_b ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Update the history on every grant, whether or not the instruction loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b <= 1'b1;
    end else if (grant[0]) begin
      r_last_b <= 1'b0;
    end else if (grant[1]) begin
      r_last_b <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_reg_ctrl.sv
//------------------------------------------------------------------------------
// Module   : instr_reg_ctrl
// Brief    : Sequences the 32-entry instruction register as a circular log:
//            arbitrates two writers, rejects divide-by-zero, serves in-order
//            readback and tracks occupancy.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_reg_ctrl
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  opcode_t     a_opcode,
  input  operand_t    a_op_a,
  input  operand_t    a_op_b,
  input  logic        b_valid,
  output logic        b_ready,
  input  opcode_t     b_opcode,
  input  operand_t    b_op_a,
  input  operand_t    b_op_b,
  input  logic        rd_req,
  output logic        load_en,
  output opcode_t     opcode,
  output operand_t    operand_a,
  output operand_t    operand_b,
  output address_t    write_pointer,
  output address_t    read_pointer,
  output logic        rd_valid,
  output logic [5:0]  count,
  output logic        full,
  output logic        empty,
  output logic        dz_err,
  output logic        rd_err
);

  localparam logic [5:0] C_FULL = 6'(DEPTH);

  ctrl_state_t r_state;
  logic [1:0]  w_grant;
  logic        w_read_take;
  logic        w_arb_en;
  logic        w_accept;
  logic        w_dz;
  opcode_t     w_sel_opc;
  operand_t    w_sel_a;
  operand_t    w_sel_b;

  // A read in IDLE preempts any write in the same cycle.
  assign w_read_take = (r_state == IDLE) && rd_req && !empty;
  assign w_arb_en    = (r_state == IDLE) && !full && !w_read_take;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_valid, a_valid}),
    .enable  (w_arb_en),
    .grant   (w_grant)
  );

  assign a_ready   = w_grant[0];
  assign b_ready   = w_grant[1];
  assign w_accept  = |w_grant;
  assign w_sel_opc = w_grant[1] ? b_opcode : a_opcode;
  assign w_sel_a   = w_grant[1] ? b_op_a   : a_op_a;
  assign w_sel_b   = w_grant[1] ? b_op_b   : a_op_b;
  assign w_dz      = w_accept && is_div_zero(w_sel_opc, w_sel_b);

  // Control FSM with registered strobes, fields, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      load_en       <= 1'b0;
      rd_valid      <= 1'b0;
      dz_err        <= 1'b0;
      rd_err        <= 1'b0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
    end else begin
      load_en  <= 1'b0;
      rd_valid <= 1'b0;
      dz_err   <= 1'b0;
      rd_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_read_take) begin
            r_state  <= READ;
            rd_valid <= 1'b1;
          end else begin
            // Reaching here with rd_req set means the log is empty.
            if (rd_req) rd_err <= 1'b1;
            if (w_accept) begin
              if (w_dz) begin
                dz_err <= 1'b1;
              end else begin
                r_state   <= LOAD;
                load_en   <= 1'b1;
                opcode    <= w_sel_opc;
                operand_a <= w_sel_a;
                operand_b <= w_sel_b;
              end
            end
          end
        end
        LOAD: begin
          write_pointer <= write_pointer + 5'd1;
          count         <= count + 6'd1;
          full          <= ((count + 6'd1) == C_FULL);
          empty         <= 1'b0;
          r_state       <= IDLE;
        end
        READ: begin
          read_pointer <= read_pointer + 5'd1;
          count        <= count - 6'd1;
          full         <= 1'b0;
          empty        <= (count == 6'd1);
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_reg_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_reg_ctrl
// Brief    : Directed self-checking bench for instr_reg_ctrl.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_reg_ctrl;
  import instr_register_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_valid, b_valid, rd_req;
  opcode_t    a_opcode, b_opcode;
  operand_t   a_op_a, a_op_b, b_op_a, b_op_b;
  logic       a_ready, b_ready, load_en, rd_valid;
  opcode_t    opcode;
  operand_t   operand_a, operand_b;
  address_t   write_pointer, read_pointer;
  logic [5:0] count;
  logic       full, empty, dz_err, rd_err;

  int n_checks = 0;
  int n_errors = 0;

  instr_reg_ctrl #(.DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_op_a(a_op_a), .a_op_b(a_op_b),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode),
    .b_op_a(b_op_a), .b_op_b(b_op_b),
    .rd_req(rd_req), .load_en(load_en), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .dz_err(dz_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    a_valid  = 1'b0; b_valid = 1'b0; rd_req = 1'b0;
    a_opcode = ZERO; b_opcode = ZERO;
    a_op_a = '0; a_op_b = '0; b_op_a = '0; b_op_b = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_load_en", load_en, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_rp", read_pointer, 0);
    chk("rst_dz", dz_err, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_opcode", opcode, ZERO);

    // Single ADD write then readback
    a_valid = 1; a_opcode = ADD; a_op_a = 5; a_op_b = 3;
    #1;
    chk("s1_a_ready", a_ready, 1);
    chk("s1_b_ready", b_ready, 0);
    tick(); a_valid = 0;
    chk("s1_load_en", load_en, 1);
    chk("s1_wp", write_pointer, 0);
    chk("s1_opcode", opcode, ADD);
    chk("s1_op_a", operand_a, 5);
    chk("s1_op_b", operand_b, 3);
    chk("s1_count_pre", count, 0);
    chk("s1_a_ready_load", a_ready, 0);
    tick();
    chk("s1_load_drop", load_en, 0);
    chk("s1_count", count, 1);
    chk("s1_empty", empty, 0);
    chk("s1_wp_inc", write_pointer, 1);
    rd_req = 1; #1;
    tick(); rd_req = 0;
    chk("s1_rd_valid", rd_valid, 1);
    chk("s1_rp", read_pointer, 0);
    tick();
    chk("s1_rd_valid_drop", rd_valid, 0);
    chk("s1_count_rd", count, 0);
    chk("s1_rp_inc", read_pointer, 1);
    chk("s1_empty_rd", empty, 1);

    // Round-robin alternation from reset: A,B,A,B
    do_reset();
    a_valid = 1; a_opcode = SUB;  a_op_a = 10; a_op_b = 4;
    b_valid = 1; b_opcode = MULT; b_op_a = 6;  b_op_b = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_ready, (i % 2 == 0));
      chk("rr_b_ready", b_ready, (i % 2 != 0));
      tick();
      chk("rr_load_en", load_en, 1);
      chk("rr_wp", write_pointer, i);
      chk("rr_opcode", opcode, (i % 2 == 0) ? SUB : MULT);
      tick();
    end
    a_valid = 0; b_valid = 0;
    chk("rr_count", count, 4);

    // Fill to 32, hold off while full, read one, wrap-around write
    do_reset();
    a_valid = 1; a_opcode = ADD; a_op_a = 1; a_op_b = 2;
    for (int i = 0; i < 32; i++) begin
      tick();
      tick();
    end
    chk("fill_count", count, 32);
    chk("fill_full", full, 1);
    chk("fill_wp_wrap", write_pointer, 0);
    b_valid = 1; #1;
    chk("fill_a_ready", a_ready, 0);
    chk("fill_b_ready", b_ready, 0);
    tick();
    chk("fill_no_load", load_en, 0);
    chk("fill_count_hold", count, 32);
    b_valid = 0;
    rd_req = 1; #1;
    tick(); rd_req = 0;
    chk("fill_rd_valid", rd_valid, 1);
    chk("fill_rp", read_pointer, 0);
    chk("fill_a_ready_rd", a_ready, 0);
    tick();
    chk("fill_count_31", count, 31);
    chk("fill_full_drop", full, 0);
    chk("fill_a_ready_held", a_ready, 1);
    tick(); a_valid = 0;
    chk("fill_wrap_load", load_en, 1);
    chk("fill_wrap_wp", write_pointer, 0);
    tick();
    chk("fill_full_again", full, 1);
    chk("fill_wp_1", write_pointer, 1);

    // Divide-by-zero rejection, then a valid MOD
    do_reset();
    b_valid = 1; b_opcode = DIV; b_op_a = 7; b_op_b = 0;
    #1;
    chk("dz_b_ready", b_ready, 1);
    tick(); b_valid = 0;
    chk("dz_err", dz_err, 1);
    chk("dz_no_load", load_en, 0);
    chk("dz_count", count, 0);
    chk("dz_wp", write_pointer, 0);
    tick();
    chk("dz_pulse_end", dz_err, 0);
    b_valid = 1; b_opcode = MOD; b_op_a = 7; b_op_b = 2;
    #1;
    chk("mod_b_ready", b_ready, 1);
    tick(); b_valid = 0;
    chk("mod_load_en", load_en, 1);
    chk("mod_opcode", opcode, MOD);
    chk("mod_op_b", operand_b, 2);
    chk("mod_dz_quiet", dz_err, 0);
    tick();
    chk("mod_count", count, 1);

    // Read while empty, then read priority over a write
    do_reset();
    rd_req = 1; #1;
    tick(); rd_req = 0;
    chk("rderr_pulse", rd_err, 1);
    chk("rderr_no_valid", rd_valid, 0);
    tick();
    chk("rderr_end", rd_err, 0);
    a_valid = 1; a_opcode = PASSA; a_op_a = 9; a_op_b = 0;
    tick(); a_valid = 0;
    tick();
    chk("prio_count1", count, 1);
    rd_req = 1; a_valid = 1; #1;
    chk("prio_a_blocked", a_ready, 0);
    tick(); rd_req = 0;
    chk("prio_rd_valid", rd_valid, 1);
    chk("prio_a_ready_rd", a_ready, 0);
    tick();
    chk("prio_count0", count, 0);
    chk("prio_rd_valid_end", rd_valid, 0);
    chk("prio_a_ready", a_ready, 1);
    tick(); a_valid = 0;
    chk("prio_load_en", load_en, 1);
    chk("prio_wp", write_pointer, 1);

    // Asynchronous reset during LOAD
    do_reset();
    a_valid = 1; a_opcode = ADD; a_op_a = 1; a_op_b = 1;
    tick(); tick(); tick(); a_valid = 0;
    chk("arst_load_en", load_en, 1);
    chk("arst_wp", write_pointer, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_load_drop", load_en, 0);
    tick();
    reset_n = 1;
    tick();
    chk("arst_count", count, 0);
    chk("arst_wp0", write_pointer, 0);
    chk("arst_rp0", read_pointer, 0);
    chk("arst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
